// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder built around one shared full adder.
// It processes one bit per cycle, LSB first, and runs IDLE -> RUN -> FIN.
// The optional subtract mode is enabled with the SERIAL_ADD_SUB_EN macro.
// When the macro is defined, the SUB port exists and A-B is computed as
// A + ~B + 1.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLKIN,
  input  logic             RESETN,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             SUB,
`endif
  output logic             READY,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] O,
  output logic             COUT
);

  localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic             carry;
  logic             a_bit;
  logic             b_bit;
  logic             sum_bit;
  logic             carry_nxt;
  logic             carry_init;
  logic             last_bit;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub_q;
`endif

  assign last_bit = (cnt == LAST);

  // State register
  always_ff @(posedge CLKIN) begin
    if (!RESETN) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (START)    state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = FIN;
      FIN:                   state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded directly from the state
  always_comb begin
    READY = (state == IDLE);
    BUSY  = (state == RUN);
    DONE  = (state == FIN);
  end

  // Shared full adder on the current bit, and the result with that bit merged in.
  // In subtract mode the B bit is inverted here and the carry starts at 1 on acceptance.
  always_comb begin
    a_bit = a_q[cnt];
`ifdef SERIAL_ADD_SUB_EN
    b_bit      = b_q[cnt] ^ sub_q;
    carry_init = SUB;
`else
    b_bit      = b_q[cnt];
    carry_init = 1'b0;
`endif
    sum_bit       = a_bit ^ b_bit ^ carry;
    carry_nxt     = (a_bit & b_bit) | (a_bit & carry) | (b_bit & carry);
    res_nxt       = res;
    res_nxt[cnt]  = sum_bit;
  end

  // Datapath: latch operands on acceptance, then do one bit per RUN cycle.
  // O and COUT are written only on the final RUN edge.
  always_ff @(posedge CLKIN) begin
    if (!RESETN) begin
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res   <= '0;
      carry <= 1'b0;
      O     <= '0;
      COUT  <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (START) begin
            a_q   <= A;
            b_q   <= B;
            carry <= carry_init;
            cnt   <= '0;
`ifdef SERIAL_ADD_SUB_EN
            sub_q <= SUB;
`endif
          end
        end
        RUN: begin
          res   <= res_nxt;
          carry <= carry_nxt;
          if (last_bit) begin
            cnt  <= '0;
            O    <= res_nxt;
            COUT <= carry_nxt;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl.
// The driver models which START requests are accepted and pushes the expected
// result for each one into a queue. A separate negedge monitor checks
// READY/BUSY/DONE timing and the O/COUT values against that queue.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         CLKIN = 1'b0;
  logic         RESETN;
  logic         START;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         READY;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] O;
  logic         COUT;
`ifdef SERIAL_ADD_SUB_EN
  logic         SUB;
  logic         SUB1;
`endif

  // Second instance with WIDTH=1
  logic         START1;
  logic [0:0]   A1;
  logic [0:0]   B1;
  logic         READY1;
  logic         BUSY1;
  logic         DONE1;
  logic [0:0]   O1;
  logic         COUT1;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .CLKIN(CLKIN), .RESETN(RESETN), .START(START), .A(A), .B(B),
`ifdef SERIAL_ADD_SUB_EN
    .SUB(SUB),
`endif
    .READY(READY), .BUSY(BUSY), .DONE(DONE), .O(O), .COUT(COUT)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .CLKIN(CLKIN), .RESETN(RESETN), .START(START1), .A(A1), .B(B1),
`ifdef SERIAL_ADD_SUB_EN
    .SUB(SUB1),
`endif
    .READY(READY1), .BUSY(BUSY1), .DONE(DONE1), .O(O1), .COUT(COUT1)
  );

  always #5 CLKIN = ~CLKIN;

  typedef struct {
    int           t;
    logic [W-1:0] o;
    logic         c;
  } exp_t;

  exp_t         q[$];
  int           cyc = 0;
  int           n_cmp = 0;
  int           n_err = 0;
  int           free_at = 0;
  bit           mon_en = 0;
  logic [W-1:0] exp_o = '0;
  logic         exp_c = 1'b0;

  always @(posedge CLKIN) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Arithmetic reference: {COUT, O}
  function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    logic [W-1:0] nb;
    nb = ~b;
    if (s) return {1'b0, a} + {1'b0, nb} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b};
  endfunction

  task automatic step();
    @(posedge CLKIN);
    #1;
  endtask

  // Drive one cycle. A request is accepted when the model says the block is idle.
  task automatic drive(input bit st, input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    logic [W:0] r;
    exp_t       e;
    START = st;
    A     = a;
    B     = b;
`ifdef SERIAL_ADD_SUB_EN
    SUB = s;
`endif
    if (st && RESETN && cyc >= free_at) begin
      r   = ref_op(a, b, s);
      e.t = cyc;
      e.o = r[W-1:0];
      e.c = r[W];
      q.push_back(e);
      free_at = cyc + W + 2;
    end
    step();
  endtask

  function automatic bit rand_sub();
`ifdef SERIAL_ADD_SUB_EN
    return bit'($urandom_range(0, 1));
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: compare outputs against the scoreboard on every falling edge
  always @(negedge CLKIN) begin
    if (mon_en) begin
      bit busy_exp;
      bit done_exp;
      exp_t e;
      busy_exp = (q.size() > 0) && (cyc > q[0].t) && (cyc <= q[0].t + W);
      done_exp = (q.size() > 0) && (cyc == q[0].t + W + 1);
      check("busy",  32'(BUSY),  32'(busy_exp));
      check("done",  32'(DONE),  32'(done_exp));
      check("ready", 32'(READY), 32'(!busy_exp && !done_exp));
      if (done_exp) begin
        e = q.pop_front();
        exp_o = e.o;
        exp_c = e.c;
      end
      check("o",    32'(O),    32'(exp_o));
      check("cout", 32'(COUT), 32'(exp_c));
    end
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           s;
  } op_t;

  initial begin
    op_t dir[$];
    int  k;
    int  t1;
    int  bound;

    RESETN = 1'b0;
    START  = 1'b0;
    A      = '0;
    B      = '0;
    START1 = 1'b0;
    A1     = '0;
    B1     = '0;
`ifdef SERIAL_ADD_SUB_EN
    SUB  = 1'b0;
    SUB1 = 1'b0;
`endif
    repeat (3) step();
    RESETN  = 1'b1;
    free_at = cyc;
    mon_en  = 1;

    // WIDTH=1 instance: 1+1 gives DONE two cycles after acceptance, with O=0 and COUT=1
    START1 = 1'b1;
    A1     = 1'b1;
    B1     = 1'b1;
    check("w1_ready0", 32'(READY1), 32'd1);
    t1 = cyc;
    step();
    START1 = 1'b0;
    A1     = 1'b0;
    check("w1_busy",  32'(BUSY1), 32'd1);
    check("w1_done0", 32'(DONE1), 32'd0);
    step();
    check("w1_cyc",  32'(cyc - t1), 32'd2);
    check("w1_done", 32'(DONE1),    32'd1);
    check("w1_o",    32'(O1),       32'd0);
    check("w1_cout", 32'(COUT1),    32'd1);
    step();
    check("w1_ready", 32'(READY1), 32'd1);
    check("w1_hold",  32'(O1),     32'd0);

    // Directed operations with START held high back-to-back; operands are junk while busy
    dir.push_back('{8'd3,   8'd5,   1'b0});
    dir.push_back('{8'd255, 8'd1,   1'b0});
    dir.push_back('{8'd1,   8'd2,   1'b0});
    dir.push_back('{8'd200, 8'd100, 1'b0});
`ifdef SERIAL_ADD_SUB_EN
    dir.push_back('{8'd5,   8'd3,   1'b1});
    dir.push_back('{8'd3,   8'd5,   1'b1});
`endif
    k = 0;
    while (k < dir.size()) begin
      if (cyc >= free_at) begin
        drive(1'b1, dir[k].a, dir[k].b, dir[k].s);
        k++;
      end else begin
        drive(1'b1, W'($urandom), W'($urandom), rand_sub());
      end
    end

    // Random traffic
    repeat (400) drive($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), rand_sub());

    // Finish with 3+5 (O=8), then reset during the 4th RUN cycle of the next operation
    while (cyc < free_at) drive(1'b0, W'($urandom), W'($urandom), 1'b0);
    drive(1'b1, 8'd3, 8'd5, 1'b0);
    while (cyc < free_at) drive(1'b0, W'($urandom), W'($urandom), 1'b0);
    t1 = cyc;
    drive(1'b1, 8'd10, 8'd20, 1'b0);
    while (cyc < t1 + 4) drive(1'b1, W'($urandom), W'($urandom), 1'b0);
    RESETN = 1'b0;
    START  = 1'b1;
    step();
    RESETN = 1'b1;
    q.delete();
    exp_o   = '0;
    exp_c   = 1'b0;
    free_at = cyc;
    START   = 1'b0;
    check("rst_o",     32'(O),     32'd0);
    check("rst_ready", 32'(READY), 32'd1);

    // Recovery after the abort
    repeat (2) drive(1'b0, '0, '0, 1'b0);
    drive(1'b1, 8'd77, 8'd99, 1'b0);
    bound = 0;
    while (q.size() > 0 && bound < 50) begin
      drive(1'b0, W'($urandom), W'($urandom), 1'b0);
      bound++;
    end
    check("drain", 32'(q.size()), 32'd0);
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
